clkdiv_mc: RTL and testbench
============================

CLKDIV_MC -- requirements
Module: clkdiv_mc

Interface
REQ-001 Parameter MSB, default 7: per-channel divider field MSB; fields are MSB+1 bits wide.
REQ-002 Parameter CH, default 4: number of independent divider channels (1..16); CW = clog2(CH), minimum 1.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 scan_mode  input  1  test bypass.
REQ-006 setb  input  1  asynchronous global enable, synchronised internally.
REQ-007 ini  input  CH  per-channel idle/phase-0 output level.
REQ-008 en  input  CH  per-channel run enable.
REQ-009 cfg_we  input  1  one-cycle configuration write strobe.
REQ-010 cfg_sel  input  CW  target channel of cfg_we.
REQ-011 cfg_dvsr, cfg_dven, cfg_dthr, cfg_phase  input  MSB+1 each  increment, modulus, duty threshold and start phase for the shadow set.
REQ-012 vld  output  1  divider-active qualifier.
REQ-013 lck  output  CH  divided clocks.
REQ-014 tick  output  CH  one-cycle wrap pulse per channel.
REQ-015 cfg_pend  output  CH  shadow set written but not yet applied.
REQ-016 cnt  output  CH*(MSB+2)  per-channel accumulators with one guard bit; channel i occupies bits [i*(MSB+2) +: MSB+2].

Function
REQ-017 vld SHALL equal rst-inverted (~rst) when scan_mode=1, otherwise the AND of a 2-flop synchroniser of setb.
REQ-018 lck[i] SHALL equal clk when scan_mode=1, otherwise the registered lck0[i].
REQ-019 Each channel SHALL hold an active set (dvsr, dven, dthr, phase) and a shadow set.
REQ-020 cfg_we SHALL load the four cfg_* values into the shadow of channel cfg_sel and set cfg_pend[cfg_sel] next cycle.
REQ-021 cfg_we with cfg_sel >= CH SHALL be ignored.
REQ-022 A channel SHALL be running when vld=1, en[i]=1 and active dven > active dvsr.
REQ-023 Running, cnt >= dven: cnt <= cnt - dven + dvsr; lck0 <= ini; tick <= 1.
REQ-024 Running, cnt < dven: cnt <= cnt + dvsr; tick <= 0; lck0 <= ~ini if cnt >= dthr, else lck0 holds.
REQ-025 Not running: cnt <= zero-extended phase; lck0 <= ini; tick <= 0.
REQ-026 All accumulator arithmetic SHALL be MSB+2 bits wide, so no intermediate value wraps for any legal configuration.
REQ-027 A pending shadow SHALL be copied to the active set on a cycle where the channel wraps (REQ-023) or is not running; cfg_pend clears on that same edge.
REQ-028 Shadow apply at a wrap SHALL NOT alter that cycle's cnt update, which uses the old active set; the new set governs from the next cycle.
REQ-029 A cfg_we to a channel that is already pending SHALL overwrite the shadow; only the last write is applied.
REQ-030 If cfg_we and an apply hit the same channel in the same cycle, the old shadow SHALL be applied and cfg_pend SHALL remain 1 with the new shadow.
REQ-031 dthr >= dven SHALL produce a constant lck = ini while running; dthr = 0 SHALL drive lck to ~ini from the first running cycle.
REQ-032 Channels SHALL be fully independent; cfg_we targets exactly one channel per cycle.
REQ-033 Deasserting en[i] or vld mid-period SHALL reload phase and force lck0 = ini on the next edge, with no partial-pulse extension.

Reset
REQ-034 rst=1 SHALL asynchronously clear the synchroniser, cnt, lck0, tick, cfg_pend, and all active and shadow sets to 0.
REQ-035 After rst, all channels SHALL be non-running (dven = dvsr = 0) until a configuration is applied.
REQ-036 Release of rst SHALL take effect at the first clk edge with no glitch on lck while scan_mode=0.

Verification
REQ-037 Basic divide: ch0 cfg dvsr=3, dven=8, dthr=4, phase=0, ini=0, en=1, setb=1 -> vld rises 2 cycles later; cnt 0,3,6,9,4,7,10,5,8,3; lck0 0,0,1,1->0 at wraps; tick at each cnt>=8; average period 8/3 cycles.
REQ-038 Glitch-free retune: while ch1 runs dvsr=1, dven=4, write dven=6 mid-period -> cfg_pend=1 until the next wrap; the wrap uses dven=4, following periods use 6; cfg_pend then 0.
REQ-039 Collision: cfg_we to ch2 on its wrap cycle -> old shadow applied, cfg_pend[2] stays 1, new values applied at the next wrap.
REQ-040 Stop/start: drop en[0] mid-high-phase -> next edge lck0=ini, cnt=phase (e.g. 5); re-enable -> counting resumes from 5.
REQ-041 Boundaries: dven=dvsr -> channel idle, lck=ini; dthr=0xFF, dven=8 -> lck never toggles; cfg_sel=CH -> no state change.
REQ-042 Reset/scan: assert rst mid-operation -> all outputs 0 immediately; scan_mode=1 -> lck mirrors clk on all channels and vld=~rst.

Source files
------------

// File: rtl/clkdiv_mc_if.sv
// Signal bundle for the multi-channel fractional clock divider.
// The master side drives configuration and enables; the slave side is the divider itself.
interface clkdiv_mc_if #(
  parameter int MSB = 7,
  parameter int CH  = 4
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW = MSB + 2;

  logic              scan_mode_i;
  logic              setb_i;
  logic [CH-1:0]     ini_i;
  logic [CH-1:0]     en_i;
  logic              cfg_we_i;
  logic [CW-1:0]     cfg_sel_i;
  logic [MSB:0]      cfg_dvsr_i;
  logic [MSB:0]      cfg_dven_i;
  logic [MSB:0]      cfg_dthr_i;
  logic [MSB:0]      cfg_phase_i;
  logic              vld_o;
  logic [CH-1:0]     lck_o;
  logic [CH-1:0]     tick_o;
  logic [CH-1:0]     cfg_pend_o;
  logic [CH*AW-1:0]  cnt_o;

  modport master (
    output scan_mode_i, setb_i, ini_i, en_i, cfg_we_i, cfg_sel_i,
           cfg_dvsr_i, cfg_dven_i, cfg_dthr_i, cfg_phase_i,
    input  vld_o, lck_o, tick_o, cfg_pend_o, cnt_o
  );

  modport slave (
    input  scan_mode_i, setb_i, ini_i, en_i, cfg_we_i, cfg_sel_i,
           cfg_dvsr_i, cfg_dven_i, cfg_dthr_i, cfg_phase_i,
    output vld_o, lck_o, tick_o, cfg_pend_o, cnt_o
  );
endinterface

// File: rtl/clkdiv_mc.sv
// Multi-channel accumulator-based clock divider with double-buffered configuration.
// Each channel adds dvsr per cycle and wraps at dven, giving an average period of dven/dvsr.
module clkdiv_mc #(
  parameter int MSB = 7,
  parameter int CH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  clkdiv_mc_if.slave  bus
);
  localparam int AW = MSB + 2;

  typedef logic [MSB:0]  fld_t;
  typedef logic [AW-1:0] acc_t;

  logic [1:0]       sync_q;
  logic             vld;
  logic [CH-1:0]    lck_w;
  logic [CH-1:0]    tick_w;
  logic [CH-1:0]    pend_w;
  logic [CH*AW-1:0] cnt_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.setb_i};
    end
  end

  assign vld = bus.scan_mode_i ? ~rst : (sync_q[0] & sync_q[1]);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    fld_t dvsr_q, dven_q, dthr_q, phase_q;
    fld_t sdvsr_q, sdven_q, sdthr_q, sphase_q;
    acc_t cnt_q, cnt_d;
    logic lck0_q, lck0_d;
    logic tick_q, tick_d;
    logic pend_q, pend_d;
    logic run, wrap, apply, hit;

    assign hit   = bus.cfg_we_i && (int'(bus.cfg_sel_i) == i);
    assign run   = vld && bus.en_i[i] && (dven_q > dvsr_q);
    assign wrap  = run && (cnt_q >= acc_t'(dven_q));
    // A wrap or an idle cycle is the only safe point to swap in a new set.
    assign apply = pend_q && (wrap || !run);

    always_comb begin
      cnt_d  = acc_t'(phase_q);
      lck0_d = bus.ini_i[i];
      tick_d = 1'b0;
      if (wrap) begin
        cnt_d  = cnt_q - acc_t'(dven_q) + acc_t'(dvsr_q);
        tick_d = 1'b1;
      end else if (run) begin
        cnt_d  = cnt_q + acc_t'(dvsr_q);
        lck0_d = (cnt_q >= acc_t'(dthr_q)) ? ~bus.ini_i[i] : lck0_q;
      end
      pend_d = hit | (pend_q & ~apply);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q    <= '0;
        lck0_q   <= 1'b0;
        tick_q   <= 1'b0;
        pend_q   <= 1'b0;
        dvsr_q   <= '0;
        dven_q   <= '0;
        dthr_q   <= '0;
        phase_q  <= '0;
        sdvsr_q  <= '0;
        sdven_q  <= '0;
        sdthr_q  <= '0;
        sphase_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        lck0_q <= lck0_d;
        tick_q <= tick_d;
        pend_q <= pend_d;
        // Apply reads the old shadow, so a colliding write stays pending.
        if (apply) begin
          dvsr_q  <= sdvsr_q;
          dven_q  <= sdven_q;
          dthr_q  <= sdthr_q;
          phase_q <= sphase_q;
        end
        if (hit) begin
          sdvsr_q  <= bus.cfg_dvsr_i;
          sdven_q  <= bus.cfg_dven_i;
          sdthr_q  <= bus.cfg_dthr_i;
          sphase_q <= bus.cfg_phase_i;
        end
      end
    end

    assign lck_w[i]           = bus.scan_mode_i ? clk : lck0_q;
    assign tick_w[i]          = tick_q;
    assign pend_w[i]          = pend_q;
    assign cnt_w[i*AW +: AW]  = cnt_q;
  end

  assign bus.vld_o      = vld;
  assign bus.lck_o      = lck_w;
  assign bus.tick_o     = tick_w;
  assign bus.cfg_pend_o = pend_w;
  assign bus.cnt_o      = cnt_w;
endmodule

// File: tb/tb_clkdiv_mc.sv
// Directed bench for clkdiv_mc: a cycle model feeds a scoreboard queue, plus literal spot checks.
module tb_clkdiv_mc;
  localparam int MSB = 7;
  localparam int CH  = 3;
  localparam int AW  = MSB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clkdiv_mc_if #(.MSB(MSB), .CH(CH)) bus ();
  clkdiv_mc #(.MSB(MSB), .CH(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [CH*AW-1:0] cnt;
    logic [CH-1:0]    lck;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    pend;
    logic             vld;
  } exp_t;

  exp_t sbQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  int mCnt[CH], mDvsr[CH], mDven[CH], mDthr[CH], mPhase[CH];
  int sDvsr[CH], sDven[CH], sDthr[CH], sPhase[CH];
  bit mLck[CH], mTick[CH], mPend[CH];
  bit mS0, mS1;

  int  cntSeq[10]  = '{3, 6, 9, 4, 7, 10, 5, 8, 3, 6};
  bit  lckSeq[10]  = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0};
  bit  tickSeq[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      mCnt[i] = 0; mDvsr[i] = 0; mDven[i] = 0; mDthr[i] = 0; mPhase[i] = 0;
      sDvsr[i] = 0; sDven[i] = 0; sDthr[i] = 0; sPhase[i] = 0;
      mLck[i] = 0; mTick[i] = 0; mPend[i] = 0;
    end
    mS0 = 0;
    mS1 = 0;
  endtask

  // One clock: predict from current inputs, queue the prediction, then compare after the edge.
  task automatic applyStimulus();
    exp_t e;
    exp_t got;
    bit vldNow, run, wrap, apply, hit;
    vldNow = bus.scan_mode_i ? !rst : (mS0 && mS1);
    for (int i = 0; i < CH; i++) begin
      run   = vldNow && bus.en_i[i] && (mDven[i] > mDvsr[i]);
      wrap  = run && (mCnt[i] >= mDven[i]);
      hit   = bus.cfg_we_i && (int'(bus.cfg_sel_i) == i);
      apply = mPend[i] && (wrap || !run);
      if (!run) begin
        mCnt[i] = mPhase[i]; mLck[i] = bus.ini_i[i]; mTick[i] = 0;
      end else if (wrap) begin
        mCnt[i] = mCnt[i] - mDven[i] + mDvsr[i]; mLck[i] = bus.ini_i[i]; mTick[i] = 1;
      end else begin
        if (mCnt[i] >= mDthr[i]) mLck[i] = !bus.ini_i[i];
        mCnt[i] = mCnt[i] + mDvsr[i]; mTick[i] = 0;
      end
      if (apply) begin
        mDvsr[i] = sDvsr[i]; mDven[i] = sDven[i]; mDthr[i] = sDthr[i]; mPhase[i] = sPhase[i];
      end
      if (hit) begin
        sDvsr[i] = bus.cfg_dvsr_i; sDven[i] = bus.cfg_dven_i;
        sDthr[i] = bus.cfg_dthr_i; sPhase[i] = bus.cfg_phase_i;
        mPend[i] = 1;
      end else if (apply) begin
        mPend[i] = 0;
      end
    end
    mS1 = mS0;
    mS0 = bus.setb_i;
    e.cnt = '0;
    for (int i = 0; i < CH; i++) begin
      e.cnt[i*AW +: AW] = mCnt[i][AW-1:0];
      e.lck[i]  = mLck[i];
      e.tick[i] = mTick[i];
      e.pend[i] = mPend[i];
    end
    e.vld = mS0 && mS1;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    got = sbQ.pop_front();
    checkOutput("cnt",  64'(bus.cnt_o),      64'(got.cnt));
    checkOutput("lck",  64'(bus.lck_o),      64'(got.lck));
    checkOutput("tick", 64'(bus.tick_o),     64'(got.tick));
    checkOutput("pend", 64'(bus.cfg_pend_o), 64'(got.pend));
    checkOutput("vld",  64'(bus.vld_o),      64'(got.vld));
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [7:0] dvsr, input logic [7:0] dven,
                          input logic [7:0] dthr, input logic [7:0] phase);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_sel_i   = sel;
    bus.cfg_dvsr_i  = dvsr;
    bus.cfg_dven_i  = dven;
    bus.cfg_dthr_i  = dthr;
    bus.cfg_phase_i = phase;
    applyStimulus();
    bus.cfg_we_i    = 1'b0;
  endtask

  initial begin
    bus.scan_mode_i = 1'b0;
    bus.setb_i      = 1'b0;
    bus.ini_i       = '0;
    bus.en_i        = '0;
    bus.cfg_we_i    = 1'b0;
    bus.cfg_sel_i   = '0;
    bus.cfg_dvsr_i  = '0;
    bus.cfg_dven_i  = '0;
    bus.cfg_dthr_i  = '0;
    bus.cfg_phase_i = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cnt",  64'(bus.cnt_o),      64'(0));
    checkOutput("rst_lck",  64'(bus.lck_o),      64'(0));
    checkOutput("rst_pend", 64'(bus.cfg_pend_o), 64'(0));
    checkOutput("rst_vld",  64'(bus.vld_o),      64'(0));
    rst = 1'b0;

    // Basic divide by 8/3 on channel 0
    bus.en_i   = 3'b001;
    bus.setb_i = 1'b1;
    cfgWrite(2'd0, 8'd3, 8'd8, 8'd4, 8'd0);
    checkOutput("vld_1cyc", 64'(bus.vld_o), 64'(0));
    applyStimulus();
    checkOutput("vld_2cyc", 64'(bus.vld_o), 64'(1));
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      checkOutput("div_cnt0",  64'(bus.cnt_o[AW-1:0]), 64'(cntSeq[k]));
      checkOutput("div_lck0",  64'(bus.lck_o[0]),      64'(lckSeq[k]));
      checkOutput("div_tick0", 64'(bus.tick_o[0]),     64'(tickSeq[k]));
    end

    // Retune channel 1 mid-period
    bus.en_i = 3'b011;
    cfgWrite(2'd1, 8'd1, 8'd4, 8'd2, 8'd0);
    applyStimulus();
    repeat (3) applyStimulus();
    cfgWrite(2'd1, 8'd1, 8'd6, 8'd2, 8'd0);
    checkOutput("retune_pend", 64'(bus.cfg_pend_o[1]), 64'(1));
    applyStimulus();
    checkOutput("retune_wrap", 64'(bus.tick_o[1]), 64'(1));
    checkOutput("retune_cnt",  64'(bus.cnt_o[AW +: AW]), 64'(1));
    checkOutput("retune_clr",  64'(bus.cfg_pend_o[1]), 64'(0));
    repeat (12) applyStimulus();

    // Write colliding with the wrap of channel 2
    bus.en_i = 3'b111;
    cfgWrite(2'd2, 8'd1, 8'd3, 8'd1, 8'd0);
    applyStimulus();
    cfgWrite(2'd2, 8'd1, 8'd5, 8'd1, 8'd0);
    for (int k = 0; k < 20; k++) begin
      if (mCnt[2] >= mDven[2]) break;
      applyStimulus();
    end
    cfgWrite(2'd2, 8'd1, 8'd4, 8'd1, 8'd0);
    checkOutput("coll_tick", 64'(bus.tick_o[2]), 64'(1));
    checkOutput("coll_pend", 64'(bus.cfg_pend_o[2]), 64'(1));
    for (int k = 0; k < 20; k++) begin
      if (!mPend[2]) break;
      applyStimulus();
    end
    checkOutput("coll_clr", 64'(bus.cfg_pend_o[2]), 64'(0));
    repeat (8) applyStimulus();

    // Stop and restart channel 0 with phase 5
    cfgWrite(2'd0, 8'd3, 8'd8, 8'd4, 8'd5);
    for (int k = 0; k < 20; k++) begin
      if (!mPend[0]) break;
      applyStimulus();
    end
    for (int k = 0; k < 20; k++) begin
      if (mLck[0]) break;
      applyStimulus();
    end
    checkOutput("stop_high", 64'(bus.lck_o[0]), 64'(1));
    bus.en_i = 3'b110;
    applyStimulus();
    checkOutput("stop_cnt", 64'(bus.cnt_o[AW-1:0]), 64'(5));
    checkOutput("stop_lck", 64'(bus.lck_o[0]), 64'(0));
    applyStimulus();
    bus.en_i = 3'b111;
    applyStimulus();
    checkOutput("restart_cnt", 64'(bus.cnt_o[AW-1:0]), 64'(8));

    // Boundaries on channel 1 with ini=1
    bus.ini_i = 3'b010;
    cfgWrite(2'd1, 8'd2, 8'd2, 8'd1, 8'd0);
    for (int k = 0; k < 20; k++) begin
      if (!mPend[1]) break;
      applyStimulus();
    end
    repeat (3) applyStimulus();
    checkOutput("eq_lck",  64'(bus.lck_o[1]), 64'(1));
    checkOutput("eq_cnt",  64'(bus.cnt_o[AW +: AW]), 64'(0));
    checkOutput("eq_tick", 64'(bus.tick_o[1]), 64'(0));
    cfgWrite(2'd1, 8'd3, 8'd8, 8'hFF, 8'd0);
    applyStimulus();
    for (int k = 0; k < 12; k++) begin
      applyStimulus();
      checkOutput("hithr_lck", 64'(bus.lck_o[1]), 64'(1));
    end
    cfgWrite(2'd3, 8'd7, 8'd9, 8'd2, 8'd1);
    checkOutput("sel_oor", 64'(bus.cfg_pend_o), 64'(0));
    repeat (3) applyStimulus();

    // dthr=0 on channel 2 and a setb drop
    cfgWrite(2'd2, 8'd1, 8'd4, 8'd0, 8'd0);
    repeat (8) applyStimulus();
    bus.setb_i = 1'b0;
    repeat (3) applyStimulus();
    bus.setb_i = 1'b1;
    repeat (5) applyStimulus();

    // Asynchronous reset mid-operation
    rst = 1'b1;
    #1;
    checkOutput("arst_cnt",  64'(bus.cnt_o),      64'(0));
    checkOutput("arst_lck",  64'(bus.lck_o),      64'(0));
    checkOutput("arst_tick", 64'(bus.tick_o),     64'(0));
    checkOutput("arst_pend", 64'(bus.cfg_pend_o), 64'(0));
    checkOutput("arst_vld",  64'(bus.vld_o),      64'(0));
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) applyStimulus();

    // Scan bypass
    bus.scan_mode_i = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("scan_lck_lo", 64'(bus.lck_o), 64'(0));
    checkOutput("scan_vld",    64'(bus.vld_o), 64'(1));
    @(posedge clk);
    #1;
    checkOutput("scan_lck_hi", 64'(bus.lck_o), 64'(3'b111));
    rst = 1'b1;
    #1;
    checkOutput("scan_vld_rst", 64'(bus.vld_o), 64'(0));
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
